// File: rtl/key_debounce_scheduler_if.sv
// Key debounce scheduler bus: raw key levels in, debounced state/pulses/status out.
// master: board/application side; slave: the scheduler.
interface key_debounce_scheduler_if #(
    parameter int N_KEYS = 4,
    parameter int IDX_W  = 2
);
    logic [N_KEYS-1:0] Key_In;
    logic [N_KEYS-1:0] Key_State;
    logic [N_KEYS-1:0] Key_Press;
    logic [N_KEYS-1:0] Key_Release;
    logic              Busy;
    logic [IDX_W-1:0]  Grant_Idx;

    modport master (
        output Key_In,
        input  Key_State,
        input  Key_Press,
        input  Key_Release,
        input  Busy,
        input  Grant_Idx
    );

    modport slave (
        input  Key_In,
        output Key_State,
        output Key_Press,
        output Key_Release,
        output Busy,
        output Grant_Idx
    );
endinterface

// File: rtl/key_debounce_scheduler.sv
// Shared-timer key debouncer: one 1 ms prescaler and ms counter are granted
// round-robin to a key whose sampled level disagrees with its debounced state.
// Holding for DEB_MS commits the new state with a one-cycle press/release pulse.
// Optional feature: define KEY_SYNC_EN to pass Key_In through a 2-FF
// synchronizer (reset to released) before sampling.
module key_debounce_scheduler #(
    parameter int N_KEYS = 4,
    parameter int T1MS   = 49_999,
    parameter int DEB_MS = 20,
    parameter int IDX_W  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    key_debounce_scheduler_if.slave  kif
);
    localparam int PW = (T1MS > 0) ? $clog2(T1MS + 1) : 1;
    localparam logic [PW-1:0]    T1MS_C = PW'(T1MS);
    localparam logic [4:0]       DEB_C  = 5'(DEB_MS);
    localparam logic [IDX_W-1:0] LAST_C = IDX_W'(N_KEYS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [4:0]        ms, ms_nxt, ms_inc;
    logic [IDX_W-1:0]  rr_ptr, rr_nxt;
    logic [IDX_W-1:0]  grant_idx, grant_nxt;
    logic [N_KEYS-1:0] key_state, key_state_nxt;
    logic [N_KEYS-1:0] press, press_nxt;
    logic [N_KEYS-1:0] release_q, release_nxt;
    logic [N_KEYS-1:0] smp, mismatch;
    logic              found, wrap;
    logic [IDX_W-1:0]  pick, cand_idx;
    int unsigned       cand;

`ifdef KEY_SYNC_EN
    logic [N_KEYS-1:0] sync_q1, sync_q2;

    // Two-stage synchronizer for asynchronous key pins, reset to released.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= kif.Key_In;
            sync_q2 <= sync_q1;
        end
    end

    assign smp = ~sync_q2;
`else
    assign smp = ~kif.Key_In;
`endif

    assign mismatch = smp ^ key_state;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_C) ? '0 : i + IDX_W'(1);
    endfunction

    // Round-robin search: first mismatching key from rr_ptr upward, wrapping.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= N_KEYS) cand = cand - N_KEYS;
            cand_idx = IDX_W'(cand);
            if (!found && mismatch[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    // Next-state and datapath: grant in IDLE, time in WAIT, toggle and pulse in COMMIT.
    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        ms_nxt        = ms;
        rr_nxt        = rr_ptr;
        grant_nxt     = grant_idx;
        key_state_nxt = key_state;
        press_nxt     = '0;
        release_nxt   = '0;
        wrap          = (presc == T1MS_C);
        ms_inc        = (wrap && ms != DEB_C) ? ms + 5'd1 : ms;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    presc_nxt = '0;
                    ms_nxt    = '0;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                presc_nxt = wrap ? '0 : presc + PW'(1);
                ms_nxt    = ms_inc;
                if (!mismatch[grant_idx]) begin
                    rr_nxt    = next_idx(grant_idx);
                    state_nxt = ST_IDLE;
                end else if (ms_inc == DEB_C) begin
                    // Compare against the incremented count so the window is exactly DEB_MS ms.
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                key_state_nxt[grant_idx] = ~key_state[grant_idx];
                press_nxt[grant_idx]     = ~key_state[grant_idx];
                release_nxt[grant_idx]   = key_state[grant_idx];
                rr_nxt                   = next_idx(grant_idx);
                state_nxt                = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            presc     <= '0;
            ms        <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            key_state <= '0;
            press     <= '0;
            release_q <= '0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            ms        <= ms_nxt;
            rr_ptr    <= rr_nxt;
            grant_idx <= grant_nxt;
            key_state <= key_state_nxt;
            press     <= press_nxt;
            release_q <= release_nxt;
        end
    end

    assign kif.Key_State   = key_state;
    assign kif.Key_Press   = press;
    assign kif.Key_Release = release_q;
    assign kif.Busy        = (state != ST_IDLE);
    assign kif.Grant_Idx   = grant_idx;
endmodule

// File: tb/tb_key_debounce_scheduler.sv
// Directed bench for key_debounce_scheduler (N_KEYS=4, T1MS=9, DEB_MS=3).
// Latency expectations follow KEY_SYNC_EN: 34 cycles with it, 32 without.
module tb_key_debounce_scheduler;
`ifdef KEY_SYNC_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 32;
`endif
    localparam int WIN = 32;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // observation statistics
    int   cyc;
    int   press_at [4];
    int   rel_at   [4];
    int   press_cnt[4];
    int   rel_cnt  [4];
    int   busy_cnt;
    int   multi_hot = 0;
    int   grants[$];
    logic prev_busy;

    key_debounce_scheduler_if #(.N_KEYS(4), .IDX_W(2)) kif ();

    key_debounce_scheduler #(
        .N_KEYS(4),
        .T1MS  (9),
        .DEB_MS(3),
        .IDX_W (2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .kif(kif)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        kif.Key_In = '1;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic obs_clear();
        cyc = 0;
        busy_cnt = 0;
        prev_busy = kif.Busy;
        grants.delete();
        for (int k = 0; k < 4; k++) begin
            press_at[k] = -1;
            rel_at[k] = -1;
            press_cnt[k] = 0;
            rel_cnt[k] = 0;
        end
    endtask

    task automatic observe(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (kif.Key_Press[k]) begin
                    if (press_at[k] < 0) press_at[k] = cyc;
                    press_cnt[k]++;
                end
                if (kif.Key_Release[k]) begin
                    if (rel_at[k] < 0) rel_at[k] = cyc;
                    rel_cnt[k]++;
                end
            end
            if (kif.Busy) busy_cnt++;
            if (kif.Busy && !prev_busy) grants.push_back(int'(kif.Grant_Idx));
            if ($countones(kif.Key_Press | kif.Key_Release) > 1) multi_hot++;
            prev_busy = kif.Busy;
        end
    endtask

    task automatic test_reset();
        kif.Key_In = '1;
        RST = 1'b1;
        tick();
        tick();
        checks++; if (kif.Key_State !== 4'b0000) begin errors++; $display("FAIL reset_state: got %b expected 0000", kif.Key_State); end
        checks++; if (kif.Key_Press !== 4'b0000) begin errors++; $display("FAIL reset_press: got %b expected 0000", kif.Key_Press); end
        checks++; if (kif.Key_Release !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b expected 0000", kif.Key_Release); end
        checks++; if (kif.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", kif.Busy); end
        checks++; if (kif.Grant_Idx !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", kif.Grant_Idx); end
        RST = 1'b0;
    endtask

    task automatic test_press();
        do_reset();
        obs_clear();
        kif.Key_In[1] = 1'b0;
        observe(LAT + 6);
        checks++; if (press_at[1] !== LAT) begin errors++; $display("FAIL press_latency: got %0d expected %0d", press_at[1], LAT); end
        checks++; if (press_cnt[1] !== 1) begin errors++; $display("FAIL press_width: got %0d expected 1", press_cnt[1]); end
        checks++; if (kif.Key_State !== 4'b0010) begin errors++; $display("FAIL press_state: got %b expected 0010", kif.Key_State); end
        checks++; if (busy_cnt !== 31) begin errors++; $display("FAIL press_busy_cycles: got %0d expected 31", busy_cnt); end
        checks++; if (kif.Grant_Idx !== 2'd1) begin errors++; $display("FAIL press_grant: got %0d expected 1", kif.Grant_Idx); end
        checks++; if (rel_cnt[1] !== 0) begin errors++; $display("FAIL press_no_release: got %0d expected 0", rel_cnt[1]); end
    endtask

    task automatic test_bounce();
        do_reset();
        obs_clear();
        kif.Key_In[1] = 1'b0;
        observe(12);
        kif.Key_In[1] = 1'b1;
        observe(40);
        checks++; if (press_cnt[1] !== 0) begin errors++; $display("FAIL bounce_no_pulse: got %0d expected 0", press_cnt[1]); end
        checks++; if (kif.Key_State !== 4'b0000) begin errors++; $display("FAIL bounce_state: got %b expected 0000", kif.Key_State); end
        checks++; if (busy_cnt !== 12) begin errors++; $display("FAIL bounce_busy_cycles: got %0d expected 12", busy_cnt); end
        checks++; if (kif.Busy !== 1'b0) begin errors++; $display("FAIL bounce_busy_end: got %b expected 0", kif.Busy); end
    endtask

    task automatic test_simultaneous();
        int g0, g1;
        do_reset();
        obs_clear();
        kif.Key_In[0] = 1'b0;
        kif.Key_In[2] = 1'b0;
        observe(LAT + WIN + 6);
        g0 = (grants.size() > 0) ? grants[0] : 99;
        g1 = (grants.size() > 1) ? grants[1] : 99;
        checks++; if (press_at[0] !== LAT) begin errors++; $display("FAIL simul_press0: got %0d expected %0d", press_at[0], LAT); end
        checks++; if (press_at[2] !== LAT + WIN) begin errors++; $display("FAIL simul_press2: got %0d expected %0d", press_at[2], LAT + WIN); end
        checks++; if (grants.size() !== 2) begin errors++; $display("FAIL simul_grant_count: got %0d expected 2", grants.size()); end
        checks++; if (g0 !== 0 || g1 !== 2) begin errors++; $display("FAIL simul_grant_order: got %0d,%0d expected 0,2", g0, g1); end
        checks++; if (kif.Key_State !== 4'b0101) begin errors++; $display("FAIL simul_state: got %b expected 0101", kif.Key_State); end
    endtask

    task automatic test_release();
        int g0;
        do_reset();
        obs_clear();
        kif.Key_In[3] = 1'b0;
        observe(LAT + 6);
        checks++; if (press_at[3] !== LAT) begin errors++; $display("FAIL rel_setup_press: got %0d expected %0d", press_at[3], LAT); end
        obs_clear();
        kif.Key_In[3] = 1'b1;
        observe(LAT + 6);
        checks++; if (rel_at[3] !== LAT) begin errors++; $display("FAIL release_latency: got %0d expected %0d", rel_at[3], LAT); end
        checks++; if (rel_cnt[3] !== 1) begin errors++; $display("FAIL release_width: got %0d expected 1", rel_cnt[3]); end
        checks++; if (press_cnt[3] !== 0) begin errors++; $display("FAIL release_no_press: got %0d expected 0", press_cnt[3]); end
        checks++; if (kif.Key_State !== 4'b0000) begin errors++; $display("FAIL release_state: got %b expected 0000", kif.Key_State); end
        // rr pointer should have wrapped to 0, so key 1 wins over key 3
        obs_clear();
        kif.Key_In[1] = 1'b0;
        kif.Key_In[3] = 1'b0;
        observe(LAT + 2);
        g0 = (grants.size() > 0) ? grants[0] : 99;
        checks++; if (g0 !== 1) begin errors++; $display("FAIL release_rr_after: got %0d expected 1", g0); end
        checks++; if (press_at[1] !== LAT) begin errors++; $display("FAIL release_rr_press1: got %0d expected %0d", press_at[1], LAT); end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        obs_clear();
        kif.Key_In[2] = 1'b0;
        observe(LAT + 6);
        checks++; if (press_at[2] !== LAT) begin errors++; $display("FAIL rr_setup_press2: got %0d expected %0d", press_at[2], LAT); end
        obs_clear();
        kif.Key_In[0] = 1'b0;
        kif.Key_In[3] = 1'b0;
        observe(LAT + WIN + 6);
        checks++; if (press_at[3] !== LAT) begin errors++; $display("FAIL rr_wrap_first3: got %0d expected %0d", press_at[3], LAT); end
        checks++; if (press_at[0] !== LAT + WIN) begin errors++; $display("FAIL rr_wrap_then0: got %0d expected %0d", press_at[0], LAT + WIN); end
        checks++; if (kif.Key_State !== 4'b1101) begin errors++; $display("FAIL rr_wrap_state: got %b expected 1101", kif.Key_State); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        obs_clear();
        kif.Key_In[1] = 1'b0;
        observe(15);
        checks++; if (kif.Busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", kif.Busy); end
        checks++; if (kif.Grant_Idx !== 2'd1) begin errors++; $display("FAIL midrst_grant_before: got %0d expected 1", kif.Grant_Idx); end
        RST = 1'b1;
        tick();
        checks++; if ({kif.Key_State, kif.Key_Press, kif.Key_Release} !== 12'h000) begin errors++; $display("FAIL midrst_outputs: got %h expected 000", {kif.Key_State, kif.Key_Press, kif.Key_Release}); end
        checks++; if (kif.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", kif.Busy); end
        checks++; if (kif.Grant_Idx !== 2'd0) begin errors++; $display("FAIL midrst_grant: got %0d expected 0", kif.Grant_Idx); end
        RST = 1'b0;
        checks++; if (press_cnt[1] !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", press_cnt[1]); end
        obs_clear();
        observe(LAT + 6);
        checks++; if (press_at[1] !== LAT) begin errors++; $display("FAIL midrst_redebounce: got %0d expected %0d", press_at[1], LAT); end
        checks++; if (kif.Key_State !== 4'b0010) begin errors++; $display("FAIL midrst_state: got %b expected 0010", kif.Key_State); end
    endtask

    initial begin
        kif.Key_In = '1;
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_release();
        test_rr_wrap();
        test_reset_mid_wait();
        checks++; if (multi_hot !== 0) begin errors++; $display("FAIL pulse_one_hot: got %0d multi-hot cycles expected 0", multi_hot); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
